coeff_ram_loader: RTL and testbench
===================================

# coeff_ram_loader

Runtime-loadable twiddle-coefficient store for the N=128 FFT datapath. It accepts a table of packed complex coefficients over a valid/ready write stream and stores them in an internal RAM. Once the table is complete, it plays the entries back sequentially, one per enabled cycle, wrapping continuously. It is the writer-side counterpart to the fixed coefficient ROMs: butterfly stages consume the same 22-bit coefficient format, but the table can be reloaded without rebuilding.

## Interface
- WIDTH, 11: bits per component (real in [2*WIDTH-1:WIDTH], imag in [WIDTH-1:0])
- SIZE, 32: table depth in entries
- ADDR_W, 5: address width, $clog2(SIZE)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset rst, synchronous, active-high
- load_start  in  1  single-cycle pulse; discards the table and begins a new load
- wr_valid  in  1  write-stream data valid
- wr_ready  out  1  write-stream ready; high only in LOAD
- wr_data  in  2*WIDTH  packed coefficient to store
- play_en  in  1  request one playback entry this cycle
- coeff_out  out  2*WIDTH  registered coefficient
- coeff_valid  out  1  coeff_out carries a new entry this cycle
- coeff_last  out  1  coinciding with coeff_valid for entry SIZE-1
- loaded  out  1  table complete; playback permitted
- wr_count  out  ADDR_W+1  number of entries accepted in the current load (0..SIZE)

## Operation
- States: EMPTY, LOAD, LOADED.
- Reset values: state EMPTY; coeff_out 0, coeff_valid 0, coeff_last 0, loaded 0, wr_ready 0, wr_count 0; read pointer 0. RAM contents are not cleared.
- EMPTY:
  - play_en is ignored.
  - wr_valid is ignored (wr_ready is 0).
  - load_start moves to LOAD.
- Entering LOAD, from any state on load_start:
  - wr_count becomes 0, loaded becomes 0, the read pointer becomes 0.
  - coeff_valid and coeff_last become 0.
- LOAD:
  - wr_ready = 1, decoded combinationally from state.
  - A beat is accepted when wr_valid && wr_ready. wr_data is written to address wr_count[ADDR_W-1:0], then wr_count increments.
  - On the beat that makes wr_count == SIZE, the next state is LOADED.
  - wr_valid held low causes a stall with no timeout.
- LOADED:
  - loaded = 1, wr_ready = 0, and wr_count stays at SIZE.
  - Each cycle with play_en = 1: coeff_out <= RAM[rd_ptr], coeff_valid <= 1, coeff_last <= (rd_ptr == SIZE-1), and rd_ptr <= (rd_ptr == SIZE-1) ? 0 : rd_ptr+1.
  - Playback is gapless across the wrap: no idle cycle between entry SIZE-1 and entry 0.
  - Each cycle with play_en = 0: coeff_valid and coeff_last become 0, while coeff_out and rd_ptr hold.
- Simultaneous events:
  - load_start together with an accepted beat in LOAD: load_start wins, the beat is discarded, and wr_count becomes 0.
  - load_start together with play_en in LOADED: load_start wins and no entry is emitted.
- Reset mid-load or mid-play returns to EMPTY; a partial table is never marked loaded.

## Timing
- Write: a beat accepted at edge k is readable by a play request sampled at edge k+1 or later. There is no RAM read-during-write hazard, because writes and reads occur in disjoint states.
- Load duration: at least SIZE cycles after the LOAD entry edge. loaded is asserted in the cycle after the final beat's edge.
- Playback latency is 1 cycle: play_en high sampled at edge n produces coeff_out/coeff_valid valid after edge n. The RAM read is synchronous and its output drives the register directly.
- Continuous play_en yields SIZE entries per SIZE cycles, with coeff_last every SIZE-th valid.
- Outputs are registered, except wr_ready, which is combinational from state only and never from wr_valid.

## Structure
- Shared package fft_coeff_pkg:
  - COEFF_W = 11, COEFF_DEPTH = 32.
  - typedef coeff_t (logic [2*COEFF_W-1:0]).
  - The state enum: EMPTY, LOAD, LOADED.
- Sub-module coeff_dpram: simple dual-port RAM with one write port and one synchronous read port, SIZE x 2*WIDTH, with no reset on the array. The FSM, counters and output registers stay in coeff_ram_loader.

## Test plan
- Reset, then play_en = 1 for 10 cycles: coeff_valid stays 0, coeff_out = 0, loaded = 0, wr_ready = 0.
- Load pattern: real = i, imag = -i (11-bit two's complement), i = 0..31, with wr_valid toggled every other cycle.
  - Expect wr_count stepping 0..32 on accepted beats only.
  - Expect loaded one cycle after beat 31.
  - Expect wr_ready = 0 afterwards.
- Hold play_en for 70 cycles after the load: coeff_out sequence is entry 0..31, 0..31, 0..5 with no gap, and coeff_last is high exactly on the two entry-31 outputs.
- Toggle play_en with pattern 1,0,0,1 mid-table: the output shows valid/invalid/invalid/valid with consecutive entries; coeff_out holds its value during the invalid cycles.
- Assert load_start at beat 17 of a load, coincident with wr_valid:
  - wr_count becomes 0 and the beat is dropped.
  - A fresh 32-beat load of pattern 0x155AA completes.
  - Playback returns all 0x155AA.
- Assert rst during playback at entry 12: all outputs are at their reset values next cycle and the state is EMPTY. A new load is required before any coeff_valid.

Source files
------------

// File: rtl/fft_coeff_pkg.sv
// Shared definitions for the FFT twiddle-coefficient blocks.
package fft_coeff_pkg;

  localparam int COEFF_W     = 11;
  localparam int COEFF_DEPTH = 32;

  typedef logic [2*COEFF_W-1:0] coeff_t;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    LOAD   = 2'd1,
    LOADED = 2'd2
  } state_t;

endpackage

// File: rtl/coeff_dpram.sv
// Simple dual-port RAM: one write port and one synchronous read port.
// The array is never reset; only the read data register is.
module coeff_dpram #(
  parameter int WIDTH  = 11,
  parameter int SIZE   = 32,
  parameter int ADDR_W = $clog2(SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [2*WIDTH-1:0]   wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [2*WIDTH-1:0]   rd_data
);

  logic [2*WIDTH-1:0] mem [SIZE];
  logic [2*WIDTH-1:0] rd_data_q, rd_data_d;

  // Write port: no reset on the storage array.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read data holds unless a read is requested.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_addr];
  end

  // Read data register; cleared on reset so the loader output starts at 0.
  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/coeff_ram_loader.sv
// Runtime-loadable twiddle-coefficient store: accepts a full table over a
// valid/ready stream, then plays it back one entry per enabled cycle, wrapping.
module coeff_ram_loader
  import fft_coeff_pkg::*;
#(
  parameter int WIDTH  = COEFF_W,
  parameter int SIZE   = COEFF_DEPTH,
  parameter int ADDR_W = $clog2(SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [2*WIDTH-1:0]   wr_data,
  input  logic                 play_en,
  output logic [2*WIDTH-1:0]   coeff_out,
  output logic                 coeff_valid,
  output logic                 coeff_last,
  output logic                 loaded,
  output logic [ADDR_W:0]      wr_count
);

  localparam logic [ADDR_W:0]   LAST_BEAT = (ADDR_W+1)'(SIZE - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SIZE - 1);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     wr_count_q, wr_count_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic                coeff_valid_q, coeff_valid_d;
  logic                coeff_last_q, coeff_last_d;
  logic                loaded_q, loaded_d;
  logic                ram_we, ram_re;

  // Next-state, counters and RAM strobes; load_start overrides everything.
  always_comb begin
    state_d       = state_q;
    wr_count_d    = wr_count_q;
    rd_ptr_d      = rd_ptr_q;
    coeff_valid_d = 1'b0;
    coeff_last_d  = 1'b0;
    loaded_d      = loaded_q;
    ram_we        = 1'b0;
    ram_re        = 1'b0;
    if (load_start) begin
      state_d    = LOAD;
      wr_count_d = '0;
      rd_ptr_d   = '0;
      loaded_d   = 1'b0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (wr_valid) begin
            ram_we     = 1'b1;
            wr_count_d = wr_count_q + 1'b1;
            if (wr_count_q == LAST_BEAT) begin
              state_d  = LOADED;
              loaded_d = 1'b1;
            end
          end
        end
        LOADED: begin
          if (play_en) begin
            ram_re        = 1'b1;
            coeff_valid_d = 1'b1;
            coeff_last_d  = (rd_ptr_q == LAST_ADDR);
            rd_ptr_d      = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= EMPTY;
      wr_count_q    <= '0;
      rd_ptr_q      <= '0;
      coeff_valid_q <= 1'b0;
      coeff_last_q  <= 1'b0;
      loaded_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_count_q    <= wr_count_d;
      rd_ptr_q      <= rd_ptr_d;
      coeff_valid_q <= coeff_valid_d;
      coeff_last_q  <= coeff_last_d;
      loaded_q      <= loaded_d;
    end
  end

  // RAM read register doubles as the coeff_out register (1-cycle latency).
  coeff_dpram #(
    .WIDTH  (WIDTH),
    .SIZE   (SIZE),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ram_we),
    .wr_addr (wr_count_q[ADDR_W-1:0]),
    .wr_data (wr_data),
    .rd_en   (ram_re),
    .rd_addr (rd_ptr_q),
    .rd_data (coeff_out)
  );

  assign wr_ready    = (state_q == LOAD);
  assign coeff_valid = coeff_valid_q;
  assign coeff_last  = coeff_last_q;
  assign loaded      = loaded_q;
  assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_coeff_ram_loader.sv
// Directed bench for coeff_ram_loader.
module tb_coeff_ram_loader;
  import fft_coeff_pkg::*;

  logic         clk = 1'b0;
  logic         rst, load_start, wr_valid, play_en;
  logic         wr_ready, coeff_valid, coeff_last, loaded;
  logic [21:0]  wr_data, coeff_out;
  logic [5:0]   wr_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  coeff_ram_loader dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .play_en     (play_en),
    .coeff_out   (coeff_out),
    .coeff_valid (coeff_valid),
    .coeff_last  (coeff_last),
    .loaded      (loaded),
    .wr_count    (wr_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // real = i, imag = -i in 11-bit two's complement
  function automatic logic [21:0] pat(input int i);
    logic [10:0] re, im;
    re = 11'(i);
    im = 11'd0 - re;
    return {re, im};
  endfunction

  // advance one clock; sample 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_start = 1'b0; wr_valid = 1'b0; play_en = 1'b0; wr_data = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    step(); step();
    chk("rst_out",    32'(coeff_out), 0);
    chk("rst_valid",  32'(coeff_valid), 0);
    chk("rst_last",   32'(coeff_last), 0);
    chk("rst_loaded", 32'(loaded), 0);
    chk("rst_ready",  32'(wr_ready), 0);
    chk("rst_count",  32'(wr_count), 0);

    // play requests in EMPTY are ignored
    rst = 1'b0; play_en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("empty_valid", 32'(coeff_valid), 0);
      chk("empty_out",   32'(coeff_out), 0);
      chk("empty_loaded",32'(loaded), 0);
      chk("empty_ready", 32'(wr_ready), 0);
    end
    play_en = 1'b0;

    // load ramp with wr_valid toggling
    load_start = 1'b1; step(); load_start = 1'b0;
    chk("ld_ready", 32'(wr_ready), 1);
    chk("ld_count0", 32'(wr_count), 0);
    for (int i = 0; i < 32; i++) begin
      wr_valid = 1'b0; wr_data = 22'h3FFFFF; step();
      chk("ld_stall_count", 32'(wr_count), 32'(i));
      chk("ld_stall_loaded", 32'(loaded), 0);
      wr_valid = 1'b1; wr_data = pat(i); step();
      chk("ld_count", 32'(wr_count), 32'(i + 1));
      chk("ld_loaded", 32'(loaded), (i == 31) ? 32'd1 : 32'd0);
    end
    wr_valid = 1'b0; step();
    chk("ld_done_ready", 32'(wr_ready), 0);
    chk("ld_done_count", 32'(wr_count), 32);
    chk("ld_done_loaded", 32'(loaded), 1);

    // 70 continuous play cycles: 0..31, 0..31, 0..5
    play_en = 1'b1;
    for (int k = 0; k < 70; k++) begin
      step();
      chk("play_valid", 32'(coeff_valid), 1);
      chk("play_out",   32'(coeff_out), 32'(pat(k % 32)));
      chk("play_last",  32'(coeff_last), ((k % 32) == 31) ? 32'd1 : 32'd0);
    end
    // play_en 1,0,0,1: entries 6, hold, hold, 7
    play_en = 1'b1; step();
    chk("tog0_valid", 32'(coeff_valid), 1);
    chk("tog0_out",   32'(coeff_out), 32'(pat(6)));
    play_en = 1'b0; step();
    chk("tog1_valid", 32'(coeff_valid), 0);
    chk("tog1_out",   32'(coeff_out), 32'(pat(6)));
    step();
    chk("tog2_valid", 32'(coeff_valid), 0);
    chk("tog2_last",  32'(coeff_last), 0);
    chk("tog2_out",   32'(coeff_out), 32'(pat(6)));
    play_en = 1'b1; step();
    chk("tog3_valid", 32'(coeff_valid), 1);
    chk("tog3_out",   32'(coeff_out), 32'(pat(7)));

    // load_start with play_en in LOADED: no entry emitted
    play_en = 1'b1; load_start = 1'b1; step();
    load_start = 1'b0; play_en = 1'b0;
    chk("ls_play_valid", 32'(coeff_valid), 0);
    chk("ls_play_out",   32'(coeff_out), 32'(pat(7)));
    chk("ls_play_loaded",32'(loaded), 0);
    chk("ls_play_count", 32'(wr_count), 0);
    chk("ls_play_ready", 32'(wr_ready), 1);

    // partial load of 17 beats, then load_start coincident with beat 17
    for (int i = 0; i < 17; i++) begin
      wr_valid = 1'b1; wr_data = pat(i + 100); step();
    end
    chk("abort_pre_count", 32'(wr_count), 17);
    wr_valid = 1'b1; wr_data = 22'h0BEEF; load_start = 1'b1; step();
    load_start = 1'b0;
    chk("abort_count",  32'(wr_count), 0);
    chk("abort_loaded", 32'(loaded), 0);
    chk("abort_ready",  32'(wr_ready), 1);
    for (int i = 0; i < 32; i++) begin
      wr_valid = 1'b1; wr_data = 22'h155AA; step();
    end
    wr_valid = 1'b0;
    chk("reload_count",  32'(wr_count), 32);
    chk("reload_loaded", 32'(loaded), 1);
    chk("reload_ready",  32'(wr_ready), 0);
    play_en = 1'b1;
    for (int k = 0; k < 32; k++) begin
      step();
      chk("reload_out",   32'(coeff_out), 32'h155AA);
      chk("reload_valid", 32'(coeff_valid), 1);
      chk("reload_last",  32'(coeff_last), (k == 31) ? 32'd1 : 32'd0);
    end
    play_en = 1'b0; step();

    // reload the ramp, play entries 0..11, then reset at entry 12
    load_start = 1'b1; step(); load_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      wr_valid = 1'b1; wr_data = pat(i); step();
    end
    wr_valid = 1'b0;
    play_en = 1'b1;
    for (int k = 0; k < 12; k++) step();
    chk("pre_rst_out", 32'(coeff_out), 32'(pat(11)));
    rst = 1'b1; step();
    chk("mid_rst_out",    32'(coeff_out), 0);
    chk("mid_rst_valid",  32'(coeff_valid), 0);
    chk("mid_rst_last",   32'(coeff_last), 0);
    chk("mid_rst_loaded", 32'(loaded), 0);
    chk("mid_rst_ready",  32'(wr_ready), 0);
    chk("mid_rst_count",  32'(wr_count), 0);
    rst = 1'b0;
    // still EMPTY: play and writes ignored until a new load
    for (int c = 0; c < 5; c++) begin
      wr_valid = 1'b1; wr_data = pat(c); step();
      chk("post_rst_valid", 32'(coeff_valid), 0);
      chk("post_rst_count", 32'(wr_count), 0);
      chk("post_rst_ready", 32'(wr_ready), 0);
    end
    idle_inputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
